spi_regfile_burst: RTL and testbench

- Parametrised SPI-slave register file; successor to the fixed single-register SPI wrapper.
- Sits behind the top-level synchronizers. All SPI inputs arrive already 2-stage synchronised to clk and are edge-detected internally (oversampled).
- Supports all four SPI modes and multi-register burst transfers with address auto-increment and wrap.
- Writes go to the config register bank; reads return the status register bank.

---
 rtl/spi_regfile_burst.sv | 238 +++++++++++++++++++++++
 tb/tb_spi_regfile_burst.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_regfile_burst.sv
// ---------------------------------------------------------------------------
// spi_regfile_burst
//
// SPI-slave register file with burst transfers. Its SPI inputs are already
// synchronised to clk and are oversampled here. All four SPI modes are
// supported. A frame starts with a command byte {wr, addr[6:0]}. It is followed
// by any number of REG_WIDTH-bit data words, and the address auto-increments
// and wraps after each word. Writes land in the config bank. Reads return
// snapshots of the status bank.
//
// Optional feature (macro SPI_WR_STROBE_EN): adds cfg_wr_strobe/cfg_wr_addr,
// a one-clk pulse and the written address on every in-range config write.
//
// Ports:
//   clk          system clock
//   rstb         asynchronous active-low reset
//   ena          enable; when low, SPI edges are ignored and state holds
//   mode         {cpol,cpha}; captured at frame start
//   spi_cs_n     chip select, active low
//   spi_clk      SPI clock
//   spi_mosi     serial data in
//   spi_miso     serial data out (0 while deselected)
//   config_regs  config bank, reg n at [n*REG_WIDTH +: REG_WIDTH]
//   status_regs  status bank, same packing
//   txn_active   high while a frame is being decoded
//   cfg_wr_strobe, cfg_wr_addr   (SPI_WR_STROBE_EN only)
// ---------------------------------------------------------------------------
module spi_regfile_burst #(
    parameter int NUM_CFG    = 16,
    parameter int NUM_STATUS = 16,
    parameter int REG_WIDTH  = 8
) (
    input  logic                          clk,
    input  logic                          rstb,
    input  logic                          ena,
    input  logic [1:0]                    mode,
    input  logic                          spi_cs_n,
    input  logic                          spi_clk,
    input  logic                          spi_mosi,
    output logic                          spi_miso,
    output logic [NUM_CFG*REG_WIDTH-1:0]  config_regs,
    input  logic [NUM_STATUS*REG_WIDTH-1:0] status_regs,
    output logic                          txn_active
`ifdef SPI_WR_STROBE_EN
    ,
    output logic                          cfg_wr_strobe,
    output logic [6:0]                    cfg_wr_addr
`endif
);

    // The shift register must hold the 8-bit command even for narrow registers.
    localparam int RX_W = (REG_WIDTH > 8) ? REG_WIDTH : 8;
    localparam logic [5:0] LAST_BIT = 6'(REG_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, CMD, WDATA, RDATA} state_t;

    state_t                         state_q, state_d;
    logic                           spi_clk_dly_q;
    logic [1:0]                     mode_q, mode_d;
    logic [5:0]                     bit_cnt_q, bit_cnt_d;
    logic [RX_W-1:0]                rx_q, rx_d;
    logic [REG_WIDTH-1:0]           tx_q, tx_d;
    logic [6:0]                     addr_q, addr_d;
    logic [NUM_CFG*REG_WIDTH-1:0]   cfg_q, cfg_d;

    logic                           rise, fall, sample_edge, shift_edge;
    logic                           word_done;
    logic [RX_W-1:0]                rx_shift;

    function automatic logic [6:0] next_addr(input logic [6:0] a, input int n);
        return (int'(a) == n - 1) ? 7'd0 : a + 7'd1;
    endfunction

    // Out-of-range status addresses read as zero.
    function automatic logic [REG_WIDTH-1:0] status_word(
        input logic [NUM_STATUS*REG_WIDTH-1:0] bank,
        input logic [6:0]                      a
    );
        logic [REG_WIDTH-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_STATUS; i++) begin
            if (a == 7'(i)) begin
                v = bank[i*REG_WIDTH +: REG_WIDTH];
            end
        end
        return v;
    endfunction

    // Edge detection. With cpol==cpha the data is sampled on the rising
    // edge and shifted on the falling edge; otherwise the roles swap.
    always_comb begin
        rise        = spi_clk & ~spi_clk_dly_q;
        fall        = ~spi_clk & spi_clk_dly_q;
        sample_edge = (mode_q[1] == mode_q[0]) ? rise : fall;
        shift_edge  = (mode_q[1] == mode_q[0]) ? fall : rise;
        word_done   = (bit_cnt_q == LAST_BIT);
        rx_shift    = {rx_q[RX_W-2:0], spi_mosi};
    end

    // Frame decoding. A chip-select release always wins, so a bit sampled
    // in the same cycle and any partial word are dropped. tx only shifts
    // after the first bit of a word has been sampled, which keeps the
    // freshly loaded MSB on MISO for both cpha settings.
    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        bit_cnt_d = bit_cnt_q;
        rx_d      = rx_q;
        tx_d      = tx_q;
        addr_d    = addr_q;
        cfg_d     = cfg_q;

        if (ena) begin
            if (spi_cs_n) begin
                state_d   = IDLE;
                bit_cnt_d = '0;
                rx_d      = '0;
                tx_d      = '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        state_d   = CMD;
                        mode_d    = mode;
                        bit_cnt_d = '0;
                        rx_d      = '0;
                        tx_d      = '0;
                    end
                    CMD: begin
                        if (sample_edge) begin
                            rx_d      = rx_shift;
                            bit_cnt_d = bit_cnt_q + 6'd1;
                            if (bit_cnt_q == 6'd7) begin
                                bit_cnt_d = '0;
                                rx_d      = '0;
                                addr_d    = rx_shift[6:0];
                                if (rx_shift[7]) begin
                                    state_d = WDATA;
                                end else begin
                                    state_d = RDATA;
                                    tx_d    = status_word(status_regs, rx_shift[6:0]);
                                    addr_d  = next_addr(rx_shift[6:0], NUM_STATUS);
                                end
                            end
                        end
                    end
                    WDATA: begin
                        if (sample_edge) begin
                            rx_d      = rx_shift;
                            bit_cnt_d = bit_cnt_q + 6'd1;
                            if (word_done) begin
                                bit_cnt_d = '0;
                                rx_d      = '0;
                                for (int i = 0; i < NUM_CFG; i++) begin
                                    if (addr_q == 7'(i)) begin
                                        cfg_d[i*REG_WIDTH +: REG_WIDTH] = rx_shift[REG_WIDTH-1:0];
                                    end
                                end
                                addr_d = next_addr(addr_q, NUM_CFG);
                            end
                        end
                    end
                    RDATA: begin
                        if (sample_edge) begin
                            bit_cnt_d = bit_cnt_q + 6'd1;
                            if (word_done) begin
                                bit_cnt_d = '0;
                                tx_d      = status_word(status_regs, addr_q);
                                addr_d    = next_addr(addr_q, NUM_STATUS);
                            end
                        end else if (shift_edge && bit_cnt_q >= 6'd1 && bit_cnt_q <= LAST_BIT) begin
                            tx_d = {tx_q[REG_WIDTH-2:0], 1'b0};
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end
        end
    end

    // The SPI clock history updates regardless of ena so that re-enabling
    // never acts on a stale edge.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q       <= IDLE;
            spi_clk_dly_q <= 1'b0;
            mode_q        <= 2'b00;
            bit_cnt_q     <= '0;
            rx_q          <= '0;
            tx_q          <= '0;
            addr_q        <= '0;
            cfg_q         <= '0;
        end else begin
            state_q       <= state_d;
            spi_clk_dly_q <= spi_clk;
            mode_q        <= mode_d;
            bit_cnt_q     <= bit_cnt_d;
            rx_q          <= rx_d;
            tx_q          <= tx_d;
            addr_q        <= addr_d;
            cfg_q         <= cfg_d;
        end
    end

    assign spi_miso    = ~spi_cs_n & tx_q[REG_WIDTH-1];
    assign config_regs = cfg_q;
    assign txn_active  = (state_q != IDLE);

`ifdef SPI_WR_STROBE_EN
    logic       cfg_wr_strobe_q, cfg_wr_strobe_d;
    logic [6:0] cfg_wr_addr_q, cfg_wr_addr_d;

    // The strobe is registered alongside the config bank, so it is high in
    // exactly the cycle the new value becomes visible.
    always_comb begin
        cfg_wr_strobe_d = 1'b0;
        cfg_wr_addr_d   = cfg_wr_addr_q;
        if (ena && !spi_cs_n && state_q == WDATA && sample_edge && word_done
            && int'(addr_q) < NUM_CFG) begin
            cfg_wr_strobe_d = 1'b1;
            cfg_wr_addr_d   = addr_q;
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            cfg_wr_strobe_q <= 1'b0;
            cfg_wr_addr_q   <= 7'd0;
        end else begin
            cfg_wr_strobe_q <= cfg_wr_strobe_d;
            cfg_wr_addr_q   <= cfg_wr_addr_d;
        end
    end

    assign cfg_wr_strobe = cfg_wr_strobe_q;
    assign cfg_wr_addr   = cfg_wr_addr_q;
`endif

endmodule

// File: tb/tb_spi_regfile_burst.sv
// ---------------------------------------------------------------------------
// tb_spi_regfile_burst
//
// Bench for spi_regfile_burst with default parameters (16 x 8-bit banks).
// An SPI master task drives whole bytes in any mode. Expected config-bank
// snapshots and expected MISO bytes are queued as stimulus is issued. They are
// popped and compared when the frame ends or the byte arrives.
// ---------------------------------------------------------------------------
module tb_spi_regfile_burst;

    localparam int HALF = 8;

    logic         clk;
    logic         rstb;
    logic         ena;
    logic [1:0]   mode;
    logic         spi_cs_n;
    logic         spi_clk;
    logic         spi_mosi;
    logic         spi_miso;
    logic [127:0] config_regs;
    logic [127:0] status_regs;
    logic         txn_active;
`ifdef SPI_WR_STROBE_EN
    logic         cfg_wr_strobe;
    logic [6:0]   cfg_wr_addr;
`endif

    int total = 0;
    int bad   = 0;

    logic [7:0]   cfgModel [16];
    logic [127:0] cfgQ [$];
    logic [7:0]   misoQ [$];

    spi_regfile_burst dut (
        .clk         (clk),
        .rstb        (rstb),
        .ena         (ena),
        .mode        (mode),
        .spi_cs_n    (spi_cs_n),
        .spi_clk     (spi_clk),
        .spi_mosi    (spi_mosi),
        .spi_miso    (spi_miso),
        .config_regs (config_regs),
        .status_regs (status_regs),
        .txn_active  (txn_active)
`ifdef SPI_WR_STROBE_EN
        ,
        .cfg_wr_strobe (cfg_wr_strobe),
        .cfg_wr_addr   (cfg_wr_addr)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef SPI_WR_STROBE_EN
    int         strobeCount = 0;
    int         strobeRun   = 0;
    int         strobeMaxRun = 0;
    logic [6:0] strobeAddr  = 7'd0;

    always @(negedge clk) begin
        if (cfg_wr_strobe) begin
            strobeCount  = strobeCount + 1;
            strobeRun    = strobeRun + 1;
            strobeAddr   = cfg_wr_addr;
            if (strobeRun > strobeMaxRun) strobeMaxRun = strobeRun;
        end else begin
            strobeRun = 0;
        end
    end
`endif

    task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic waitClk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] packModel();
        logic [127:0] p;
        for (int i = 0; i < 16; i++) p[i*8 +: 8] = cfgModel[i];
        return p;
    endfunction

    task automatic expectCfg();
        cfgQ.push_back(packModel());
    endtask

    task automatic compareCfg(input string tag);
        if (cfgQ.size() == 0) begin
            checkOutput({tag, "_noexp"}, 128'd1, 128'd0);
        end else begin
            checkOutput(tag, config_regs, cfgQ.pop_front());
        end
    endtask

    task automatic startFrame(input logic [1:0] m);
        mode    = m;
        spi_clk = m[1];
        waitClk(4);
        spi_cs_n = 1'b0;
        waitClk(4);
    endtask

    task automatic endFrame();
        waitClk(4);
        spi_cs_n = 1'b1;
        waitClk(6);
    endtask

    // One SPI word from the master side, MSB first; MISO is captured at the
    // point the master would sample it.
    task automatic applyStimulus(input logic [7:0] txByte, input int nBits, output logic [7:0] rxByte);
        rxByte = 8'h00;
        for (int i = 0; i < nBits; i++) begin
            if (!mode[0]) begin
                spi_mosi = txByte[7-i];
                waitClk(HALF);
                rxByte  = {rxByte[6:0], spi_miso};
                spi_clk = ~mode[1];
                waitClk(HALF);
                spi_clk = mode[1];
            end else begin
                spi_clk  = ~mode[1];
                spi_mosi = txByte[7-i];
                waitClk(HALF);
                rxByte  = {rxByte[6:0], spi_miso};
                spi_clk = mode[1];
                waitClk(HALF);
            end
        end
    endtask

    task automatic readByte(input string tag);
        logic [7:0] r;
        applyStimulus(8'h00, 8, r);
        if (misoQ.size() == 0) begin
            checkOutput({tag, "_noexp"}, 128'd1, 128'd0);
        end else begin
            checkOutput(tag, {120'd0, r}, {120'd0, misoQ.pop_front()});
        end
    endtask

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [7:0] r;
        rstb        = 1'b0;
        ena         = 1'b1;
        mode        = 2'b00;
        spi_cs_n    = 1'b1;
        spi_clk     = 1'b0;
        spi_mosi    = 1'b0;
        status_regs = '0;
        status_regs[0*8 +: 8]  = 8'hCA;
        status_regs[1*8 +: 8]  = 8'h10;
        status_regs[15*8 +: 8] = 8'hE7;
        for (int i = 0; i < 16; i++) cfgModel[i] = 8'h00;

        waitClk(3);
        checkOutput("reset_cfg", config_regs, 128'd0);
        checkOutput("reset_miso", {127'd0, spi_miso}, 128'd0);
        checkOutput("reset_txn", {127'd0, txn_active}, 128'd0);
`ifdef SPI_WR_STROBE_EN
        checkOutput("reset_strobe", {127'd0, cfg_wr_strobe}, 128'd0);
        checkOutput("reset_wraddr", {121'd0, cfg_wr_addr}, 128'd0);
`endif
        rstb = 1'b1;
        waitClk(3);

        // Mode 0 single write to reg0
        $display("[TB] mode 0 write");
        cfgModel[0] = 8'hA5;
        expectCfg();
        startFrame(2'b00);
        applyStimulus(8'h80, 8, r);
        checkOutput("m0_txn_mid", {127'd0, txn_active}, 128'd1);
        applyStimulus(8'hA5, 8, r);
        endFrame();
        checkOutput("m0_txn_after", {127'd0, txn_active}, 128'd0);
        compareCfg("m0_cfg");

        // Mode 1 burst across the config wrap point
        $display("[TB] mode 1 burst wrap");
        cfgModel[14] = 8'h11;
        cfgModel[15] = 8'h22;
        cfgModel[0]  = 8'h33;
        expectCfg();
        startFrame(2'b01);
        applyStimulus(8'h8E, 8, r);
        applyStimulus(8'h11, 8, r);
        applyStimulus(8'h22, 8, r);
        applyStimulus(8'h33, 8, r);
        endFrame();
        compareCfg("m1_cfg");

        // Mode 3 burst read
        $display("[TB] mode 3 read");
        startFrame(2'b11);
        misoQ.push_back(8'hCA);
        misoQ.push_back(8'h10);
        applyStimulus(8'h00, 8, r);
        checkOutput("m3_cmd_miso", {120'd0, r}, 128'd0);
        readByte("m3_rd0");
        readByte("m3_rd1");
        endFrame();
        checkOutput("m3_miso_idle", {127'd0, spi_miso}, 128'd0);

        // Mode 0 read across the status wrap point
        $display("[TB] mode 0 read wrap");
        startFrame(2'b00);
        misoQ.push_back(8'hE7);
        misoQ.push_back(8'hCA);
        applyStimulus(8'h0F, 8, r);
        readByte("m0_rd15");
        readByte("m0_rdwrap");
        endFrame();

        // Mode 2 partial word is discarded, then a full write lands
        $display("[TB] mode 2 partial word");
        expectCfg();
        startFrame(2'b10);
        applyStimulus(8'h81, 8, r);
        applyStimulus(8'hFF, 5, r);
        endFrame();
        compareCfg("m2_partial");
        cfgModel[1] = 8'h3C;
        expectCfg();
        startFrame(2'b10);
        applyStimulus(8'h81, 8, r);
        applyStimulus(8'h3C, 8, r);
        endFrame();
        compareCfg("m2_full");

        // Out-of-range write and read
        $display("[TB] out of range");
`ifdef SPI_WR_STROBE_EN
        begin
            int before;
            before = strobeCount;
`endif
        expectCfg();
        startFrame(2'b00);
        applyStimulus(8'hA0, 8, r);
        applyStimulus(8'h77, 8, r);
        endFrame();
        compareCfg("oor_write");
`ifdef SPI_WR_STROBE_EN
            checkOutput("oor_nostrobe", 128'(strobeCount - before), 128'd0);
            before = strobeCount;
            cfgModel[0] = 8'h5A;
            expectCfg();
            startFrame(2'b00);
            applyStimulus(8'h80, 8, r);
            applyStimulus(8'h5A, 8, r);
            endFrame();
            compareCfg("strobe_cfg");
            checkOutput("strobe_count", 128'(strobeCount - before), 128'd1);
            checkOutput("strobe_width", 128'(strobeMaxRun), 128'd1);
            checkOutput("strobe_addr", {121'd0, strobeAddr}, 128'd0);
        end
`endif
        startFrame(2'b00);
        misoQ.push_back(8'h00);
        applyStimulus(8'h20, 8, r);
        readByte("oor_read");
        endFrame();

        // Disabled block ignores a complete frame
        $display("[TB] ena low");
        ena = 1'b0;
        expectCfg();
        startFrame(2'b00);
        applyStimulus(8'h84, 8, r);
        checkOutput("ena_txn", {127'd0, txn_active}, 128'd0);
        applyStimulus(8'h55, 8, r);
        endFrame();
        ena = 1'b1;
        waitClk(2);
        compareCfg("ena_cfg");

        // Reset in the middle of a data word
        $display("[TB] reset mid write");
        startFrame(2'b00);
        applyStimulus(8'h83, 8, r);
        applyStimulus(8'hFF, 4, r);
        rstb = 1'b0;
        waitClk(2);
        checkOutput("rst_cfg", config_regs, 128'd0);
        checkOutput("rst_txn", {127'd0, txn_active}, 128'd0);
        spi_cs_n = 1'b1;
        spi_clk  = 1'b0;
        rstb     = 1'b1;
        waitClk(4);
        for (int i = 0; i < 16; i++) cfgModel[i] = 8'h00;
        cfgModel[2] = 8'h99;
        expectCfg();
        startFrame(2'b00);
        applyStimulus(8'h82, 8, r);
        applyStimulus(8'h99, 8, r);
        endFrame();
        compareCfg("post_rst_cfg");

        // Random burst in mode 1 starting at a random address
        $display("[TB] random burst");
        begin
            logic [3:0] a;
            logic [7:0] d [3];
            a = 4'($urandom_range(0, 15));
            for (int i = 0; i < 3; i++) begin
                d[i] = 8'($urandom);
                cfgModel[4'(a + 4'(i))] = d[i];
            end
            expectCfg();
            startFrame(2'b01);
            applyStimulus({4'h8, a}, 8, r);
            for (int i = 0; i < 3; i++) applyStimulus(d[i], 8, r);
            endFrame();
            compareCfg("rand_cfg");
        end

        checkOutput("queues_drained", 128'(cfgQ.size() + misoQ.size()), 128'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
